// File: rtl/piso_arb_ctrl.sv
// piso_arb_ctrl: round-robin front end for a shared piso shift register.
// Two requesters hand over words via valid/ready. The block loads the
// winning word into the piso and sequences WIDTH shift cycles. It then
// waits GAP idle cycles and flags which so bits belong to which frame.
module piso_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             piso_load,
  output logic [WIDTH-1:0] piso_pi,
  output logic             frame_valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic             frame_src,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic             last_grant_q;
  logic             src_q;
  logic             grant0, grant1;

  // State register; the partial frame is simply dropped on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, arbitration and per-state strobes
  always_comb begin
    state_d     = state_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    piso_load   = 1'b0;
    frame_valid = 1'b0;
    frame_first = 1'b0;
    frame_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Tie goes to the requester that was not granted last time;
        // reset is folded in so no ready escapes while rst is high.
        grant0 = !rst && req0_valid && (!req1_valid ||  last_grant_q);
        grant1 = !rst && req1_valid && (!req0_valid || !last_grant_q);
        if (grant0 || grant1) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        piso_load = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        frame_valid = 1'b1;
        frame_first = (bit_cnt_q == '0);
        frame_last  = (bit_cnt_q == BIT_LAST);
        if (bit_cnt_q == BIT_LAST) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Captured word, ownership, fairness pointer and cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      if (grant0 || grant1) begin
        hold_q       <= grant1 ? req1_data : req0_data;
        src_q        <= grant1;
        last_grant_q <= grant1;
      end
      if (state_q == ST_LOAD)
        bit_cnt_q <= '0;
      else if (state_q == ST_SHIFT && bit_cnt_q != BIT_LAST)
        bit_cnt_q <= bit_cnt_q + 1'b1;
      if (state_q == ST_GAP) gap_cnt_q <= gap_cnt_q + 4'd1;
      else                   gap_cnt_q <= 4'd0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign piso_pi    = hold_q;
  assign frame_src  = src_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Bench for piso_arb_ctrl: instance A (WIDTH=4, GAP=1) and instance B
// (WIDTH=8, GAP=0). Each drives a small piso model. A scoreboard queues
// accepted words and checks every so bit and frame flag as it appears.
module tb_piso_arb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic       a_v0 = 1'b0, a_v1 = 1'b0;
  logic [3:0] a_d0 = '0, a_d1 = '0;
  logic       a_r0, a_r1, a_load, a_fv, a_ff, a_fl, a_src, a_busy;
  logic [3:0] a_pi, a_sr;
  logic       a_so;

  piso_arb_ctrl #(.WIDTH(4), .GAP(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .piso_load(a_load), .piso_pi(a_pi), .frame_valid(a_fv),
    .frame_first(a_ff), .frame_last(a_fl), .frame_src(a_src), .busy(a_busy)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst)         a_sr <= '0;
    else if (a_load) a_sr <= a_pi;
    else             a_sr <= {a_sr[2:0], 1'b0};
  assign a_so = a_sr[3];

  // ---------------- instance B ----------------
  logic       b_v0 = 1'b0, b_v1 = 1'b0;
  logic [7:0] b_d0 = '0, b_d1 = '0;
  logic       b_r0, b_r1, b_load, b_fv, b_ff, b_fl, b_src, b_busy;
  logic [7:0] b_pi, b_sr;
  logic       b_so;

  piso_arb_ctrl #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .piso_load(b_load), .piso_pi(b_pi), .frame_valid(b_fv),
    .frame_first(b_ff), .frame_last(b_fl), .frame_src(b_src), .busy(b_busy)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst)         b_sr <= '0;
    else if (b_load) b_sr <= b_pi;
    else             b_sr <= {b_sr[6:0], 1'b0};
  assign b_so = b_sr[7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard A ----------------
  typedef struct {
    logic [3:0] data;
    logic       src;
    int         hs;
  } item_t;

  item_t sbq[$];
  int    grants[$];
  int    firsts[$];
  int    lasts[$];
  int    loads[$];
  int    kbit = 0;
  int    nbits = 0;
  int    busy_cnt = 0;
  int    rdy0_cnt = 0;

  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      sbq.delete();
      kbit = 0;
    end else begin
      check("a_ready_while_busy", {30'd0, a_busy & a_r0, a_busy & a_r1}, 0);
      if (a_v0 && a_r0) begin sbq.push_back('{a_d0, 1'b0, cyc}); grants.push_back(0); end
      if (a_v1 && a_r1) begin sbq.push_back('{a_d1, 1'b1, cyc}); grants.push_back(1); end
      if (a_load) loads.push_back(cyc);
      if (a_busy) busy_cnt++;
      if (a_r0)   rdy0_cnt++;
      if (a_fv) begin
        if (sbq.size() == 0) begin
          check("a_unexpected_frame", 1, 0);
        end else begin
          it = sbq[0];
          check("a_so",    a_so,  it.data[3-kbit]);
          check("a_first", a_ff,  kbit == 0);
          check("a_last",  a_fl,  kbit == 3);
          check("a_src",   a_src, it.src);
          nbits++;
          if (kbit == 0) begin
            check("a_latency", cyc - it.hs, 2);
            firsts.push_back(cyc);
          end
          if (kbit == 3) begin
            lasts.push_back(cyc);
            void'(sbq.pop_front());
            kbit = 0;
          end else begin
            kbit++;
          end
        end
      end
    end
  end

  // ---------------- scoreboard B ----------------
  int         bq[$];
  int         bk = 0;
  int         bfr = 0;
  int         bprev = -1;
  logic [7:0] bword = 8'h81;

  always @(negedge clk) begin
    if (rst) begin
      bq.delete();
      bk = 0;
      bprev = -1;
    end else begin
      if (b_v1 && b_r1) bq.push_back(cyc);
      if (b_fv) begin
        check("b_so",    b_so,  bword[7-bk]);
        check("b_first", b_ff,  bk == 0);
        check("b_last",  b_fl,  bk == 7);
        check("b_src",   b_src, 1);
        if (bk == 0) begin
          if (bq.size() > 0) check("b_latency", cyc - bq[0], 2);
          else               check("b_unexpected_frame", 1, 0);
          if (bprev >= 0) check("b_period", cyc - bprev, 10);
          bprev = cyc;
        end
        if (bk == 7) begin
          bk = 0;
          bfr++;
          if (bq.size() > 0) void'(bq.pop_front());
        end else begin
          bk++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int n, input logic [7:0] d);
    bit ok = 0;
    if (n == 0) begin a_v0 = 1'b1; a_d0 = d[3:0]; end
    else        begin a_v1 = 1'b1; a_d1 = d[3:0]; end
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((n == 0) ? a_r0 : a_r1) begin ok = 1; break; end
      @(posedge clk);
    end
    @(posedge clk) #1;
    if (n == 0) a_v0 = 1'b0;
    else        a_v1 = 1'b0;
    if (!ok) check("a_handshake_timeout", 0, 1);
  endtask

  task automatic wait_idle_a();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!a_busy && !a_v0 && !a_v1 && sbq.size() == 0) begin done = 1; break; end
    end
    if (!done) check("a_idle_timeout", 0, 1);
    @(posedge clk) #1;
  endtask

  task automatic clr();
    grants.delete(); firsts.delete(); lasts.delete(); loads.delete();
    busy_cnt = 0; rdy0_cnt = 0; nbits = 0;
  endtask

  task automatic pulse_rst();
    @(posedge clk) #3 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          {a_r0, a_r1, a_load, a_fv, a_ff, a_fl, a_src, a_busy, a_pi}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // reset state with both requesters pushing
    a_v0 = 1'b1; a_v1 = 1'b1;
    #12;
    check_all_zero("reset");
    check("b_reset_busy", {b_busy, b_r0, b_r1, b_fv}, 0);
    a_v0 = 1'b0; a_v1 = 1'b0;
    @(posedge clk) #1 rst = 1'b0;
    @(posedge clk) #1;

    // single frame from req0
    clr();
    send(0, 8'h0A);
    wait_idle_a();
    check("t1_busy_cycles", busy_cnt, 6);
    check("t1_ready_cycles", rdy0_cnt, 1);
    check("t1_frames", firsts.size(), 1);
    if (firsts.size() == 1 && loads.size() == 1 && lasts.size() == 1) begin
      check("t1_load_before_first", firsts[0] - loads[0], 1);
      check("t1_frame_len", lasts[0] - firsts[0], 3);
    end

    // simultaneous requests after a fresh reset
    pulse_rst();
    clr();
    fork
      send(0, 8'h03);
      send(1, 8'h0C);
    join
    wait_idle_a();
    check("t2_grants", grants.size(), 2);
    if (grants.size() == 2) begin
      check("t2_grant0", grants[0], 0);
      check("t2_grant1", grants[1], 1);
    end
    if (firsts.size() == 2) check("t2_spacing", firsts[1] - firsts[0], 7);
    else                    check("t2_frames", firsts.size(), 2);

    // continuous contention for six frames
    clr();
    fork
      begin repeat (3) send(0, 8'($urandom_range(0, 15))); end
      begin repeat (3) send(1, 8'($urandom_range(0, 15))); end
    join
    wait_idle_a();
    check("t3_grants", grants.size(), 6);
    if (grants.size() == 6)
      for (int i = 0; i < 6; i++) check("t3_alternate", grants[i], i % 2);
    if (firsts.size() == 6)
      for (int i = 1; i < 6; i++) check("t3_period", firsts[i] - firsts[i-1], 7);

    // req1 raised in the middle of a req0 frame
    clr();
    send(0, 8'h0B);
    @(posedge clk);
    @(posedge clk) #1;
    send(1, 8'h06);
    wait_idle_a();
    check("t4_grants", grants.size(), 2);
    if (loads.size() == 2 && lasts.size() >= 1)
      check("t4_restart_gap", loads[1] - lasts[0], 3);
    else
      check("t4_loads", loads.size(), 2);

    // reset during the second shift cycle
    clr();
    send(0, 8'h05);
    @(posedge clk);
    @(posedge clk) #2;
    check("t5_in_shift", a_fv, 1);
    #1 rst = 1'b1;
    a_v0 = 1'b1; a_d0 = 4'h6;
    a_v1 = 1'b1; a_d1 = 4'h9;
    #1;
    check_all_zero("t5_async_reset");
    @(posedge clk) #1 rst = 1'b0;
    clr();
    fork
      send(0, 8'h06);
      send(1, 8'h09);
    join
    wait_idle_a();
    check("t5_grants", grants.size(), 2);
    if (grants.size() == 2) check("t5_first_grant", grants[0], 0);
    check("t5_bits_sent", nbits, 8);

    // instance B: repeated 8'h81 frames from req1, no gap
    b_d1 = 8'h81;
    b_v1 = 1'b1;
    for (int i = 0; i < 200 && bfr < 4; i++) @(negedge clk);
    @(posedge clk) #1 b_v1 = 1'b0;
    for (int i = 0; i < 100 && (b_busy || bq.size() != 0); i++) @(negedge clk);
    check("b_frames_seen", bfr >= 4, 1);
    check("b_idle_at_end", {b_busy, b_r0, b_r1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
